// File: rtl/fpu_float_normalize.sv
// fpu_float_normalize: one-bit-per-cycle normalizer feeding the rounding stage.
module fpu_float_normalize #(
  parameter int MANTISSA_WIDTH = 48,
  parameter int EXPONENT_WIDTH = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_sign,
  input  logic [EXPONENT_WIDTH-1:0] in_exponent,
  input  logic [MANTISSA_WIDTH-1:0] in_mantissa,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [31:0]               out_number,
  output logic [2:0]                out_guard,
  output logic                      out_overflow,
  output logic                      out_underflow
);
  localparam int W = MANTISSA_WIDTH;
  localparam int E = EXPONENT_WIDTH;
  localparam logic signed [E:0] ONE = (E+1)'(1);
  localparam logic signed [E:0] EMAX = (E+1)'(255);
  typedef enum logic [1:0] {IDLE, SHIFT, PACK, OUT} state_t;
  state_t state;
  logic sign_q, sticky_q;
  logic signed [E:0] exp_q;
  logic [W-1:0] mant_q, mant_r;
  logic mant_zero, do_right, do_left, is_ovf, denorm;
  logic [7:0] exp_field;
  logic [2:0] grs;
  always_comb begin
    mant_r    = mant_q >> 1;
    mant_zero = (mant_q == '0) && !sticky_q;
    do_right  = mant_q[W-1] || (exp_q < ONE);
    do_left   = !mant_q[W-2] && (exp_q > ONE);
    is_ovf    = exp_q >= EMAX;
    denorm    = (exp_q == ONE) && !mant_q[W-2];
    exp_field = denorm ? 8'd0 : exp_q[7:0];
    grs       = {mant_q[W-26], mant_q[W-27], (|mant_q[W-28:0]) | sticky_q};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      in_ready      <= 1'b1;
      out_valid     <= 1'b0;
      out_number    <= '0;
      out_guard     <= '0;
      out_overflow  <= 1'b0;
      out_underflow <= 1'b0;
      sign_q        <= 1'b0;
      sticky_q      <= 1'b0;
      exp_q         <= '0;
      mant_q        <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          sign_q   <= in_sign;
          exp_q    <= {in_exponent[E-1], in_exponent};
          mant_q   <= in_mantissa;
          sticky_q <= 1'b0;
          in_ready <= 1'b0;
          state    <= SHIFT;
        end
        SHIFT: if (mant_zero) begin
          exp_q <= '0;
          state <= PACK;
        end else if (do_right) begin
          mant_q   <= mant_r;
          sticky_q <= sticky_q | mant_q[0];
          // a fully drained denormal parks at exponent 1 so right shifts stop
          exp_q    <= (mant_r == '0 && exp_q < ONE) ? ONE : exp_q + ONE;
        end else if (do_left) begin
          mant_q <= mant_q << 1;
          exp_q  <= exp_q - ONE;
        end else begin
          state <= PACK;
        end
        PACK: begin
          out_valid     <= 1'b1;
          out_number    <= is_ovf ? {sign_q, 8'hFF, 23'b0} : {sign_q, exp_field, mant_q[W-3 -: 23]};
          out_guard     <= is_ovf ? 3'b000 : grs;
          out_overflow  <= is_ovf;
          out_underflow <= !is_ovf && (exp_field == 8'd0) && (grs != 3'b000);
          state         <= OUT;
        end
        OUT: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fpu_float_normalize.sv
// tb_fpu_float_normalize: directed scoreboard bench for the normalizer.
module tb_fpu_float_normalize;
  localparam int W = 48;
  localparam int E = 10;
  typedef struct {
    logic [31:0] num;
    logic [2:0]  g;
    logic        ovf;
    logic        unf;
    int          lat_min;
    int          lat_max;
  } exp_t;
  logic clk = 0, rst = 1, in_valid = 0, in_sign = 0, out_ready = 1;
  logic in_ready, out_valid, out_overflow, out_underflow;
  logic [E-1:0] in_exponent = '0;
  logic [W-1:0] in_mantissa = '0;
  logic [31:0] out_number;
  logic [2:0] out_guard;
  int compared = 0, mismatched = 0;
  exp_t sb[$];
  always #5 clk = ~clk;
  fpu_float_normalize #(.MANTISSA_WIDTH(W), .EXPONENT_WIDTH(E)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exponent(in_exponent), .in_mantissa(in_mantissa),
    .out_valid(out_valid), .out_ready(out_ready), .out_number(out_number),
    .out_guard(out_guard), .out_overflow(out_overflow), .out_underflow(out_underflow)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask
  task automatic push(input logic [31:0] num, input logic [2:0] g, input logic ovf, input logic unf,
                      input int lmin, input int lmax);
    exp_t x;
    x.num = num; x.g = g; x.ovf = ovf; x.unf = unf; x.lat_min = lmin; x.lat_max = lmax;
    sb.push_back(x);
  endtask
  task automatic launch(input logic s, input int e, input logic [W-1:0] m);
    @(posedge clk); #1;
    chk("in_ready_idle", {31'b0, in_ready}, 1);
    in_valid = 1; in_sign = s; in_exponent = e[E-1:0]; in_mantissa = m;
    @(posedge clk); #1;
    in_valid = 0;
  endtask
  task automatic await_out(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < W + 10) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask
  task automatic check_out(input int cyc);
    exp_t x;
    chk("out_valid", {31'b0, out_valid}, 1);
    if (sb.size() == 0) begin
      chk("sb_nonempty", 0, 1);
    end else begin
      x = sb.pop_front();
      chk("number", out_number, x.num);
      chk("guard", {29'b0, out_guard}, {29'b0, x.g});
      chk("overflow", {31'b0, out_overflow}, {31'b0, x.ovf});
      chk("underflow", {31'b0, out_underflow}, {31'b0, x.unf});
      chk("lat_min", (cyc >= x.lat_min) ? 32'd1 : 32'd0, 1);
      chk("lat_max", (cyc <= x.lat_max) ? 32'd1 : 32'd0, 1);
    end
    chk("in_ready_busy", {31'b0, in_ready}, 0);
  endtask
  task automatic finish_hs;
    @(posedge clk); #1;
    chk("out_valid_drop", {31'b0, out_valid}, 0);
    chk("in_ready_back", {31'b0, in_ready}, 1);
  endtask
  task automatic run(input logic s, input int e, input logic [W-1:0] m, input logic [31:0] num,
                     input logic [2:0] g, input logic ovf, input logic unf, input int lmin, input int lmax);
    int cyc;
    push(num, g, ovf, unf, lmin, lmax);
    launch(s, e, m);
    await_out(cyc);
    check_out(cyc);
    finish_hs();
  endtask
  localparam logic [W-1:0] ONE_M = 48'd1 << 46;
  initial begin
    int cyc;
    logic seen;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 0);
    chk("rst_number", out_number, 0);
    chk("rst_guard", {29'b0, out_guard}, 0);
    chk("rst_ovf", {31'b0, out_overflow}, 0);
    chk("rst_unf", {31'b0, out_underflow}, 0);
    rst = 0;
    @(posedge clk); #1;
    chk("rel_in_ready", {31'b0, in_ready}, 1);
    run(0, 127, ONE_M, 32'h3F800000, 3'b000, 0, 0, 2, 2);
    run(0, 127, (48'd1 << 47) | 48'd1, 32'h40000000, 3'b001, 0, 0, 3, 3);
    run(1, 127, (48'd1 << 47) | 48'd1, 32'hC0000000, 3'b001, 0, 0, 3, 3);
    run(0, 127, 48'd1 << 40, 32'h3C800000, 3'b000, 0, 0, 8, 8);
    run(0, 300, ONE_M, 32'h7F800000, 3'b000, 1, 0, 2, 2);
    run(0, -10, ONE_M, 32'h00001000, 3'b000, 0, 0, 13, 13);
    run(0, -200, ONE_M | 48'd1, 32'h00000000, 3'b001, 0, 1, 2, W + 3);
    run(1, 50, 48'd0, 32'h80000000, 3'b000, 0, 0, 2, 2);
    run(0, 130, 48'h5555_5555_5555 >> 1, 32'h40AAAAAA, 3'b101, 0, 0, 3, 3);
    // consumer stall: result must hold and a second operand must be ignored
    out_ready = 0;
    push(32'h3F800000, 3'b000, 0, 0, 2, 2);
    launch(0, 127, ONE_M);
    await_out(cyc);
    check_out(cyc);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1; in_exponent = 10'd140; in_mantissa = 48'd1 << 40;
      @(posedge clk); #1;
      chk("hold_valid", {31'b0, out_valid}, 1);
      chk("hold_number", out_number, 32'h3F800000);
      chk("hold_in_ready", {31'b0, in_ready}, 0);
    end
    in_valid = 0;
    out_ready = 1;
    finish_hs();
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      seen |= out_valid;
    end
    chk("no_second_out", {31'b0, seen}, 0);
    // reset mid-shift discards the operand
    push(32'h3C800000, 3'b000, 0, 0, 8, 8);
    launch(0, 127, 48'd1 << 40);
    repeat (3) @(posedge clk);
    #1 rst = 1;
    #1 chk("rst_mid_valid", {31'b0, out_valid}, 0);
    @(posedge clk); #1;
    rst = 0;
    #1;
    chk("rst_rel_valid", {31'b0, out_valid}, 0);
    chk("rst_rel_ready", {31'b0, in_ready}, 1);
    void'(sb.pop_back());
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      seen |= out_valid;
    end
    chk("no_stale", {31'b0, seen}, 0);
    run(0, 127, ONE_M, 32'h3F800000, 3'b000, 0, 0, 2, 2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
